// File: rtl/rtc_pkg.sv
// Shared widths and constants for the PTP real-time clock.
// The accumulator carries 30 integer ns bits above a 32-bit fraction.
package rtc_pkg;
    localparam int NS_W     = 38;
    localparam int SEC_W    = 48;
    localparam int PERIOD_W = 40;
    localparam int ADJ_W    = 32;
    localparam int ACC_W    = 62;
    localparam logic [NS_W-1:0] NS_1E9 = 38'h3B9ACA0000;

    // The period's integer part is non-negative, so it simply zero-extends.
    function automatic logic [ACC_W-1:0] widen_inc(input logic [PERIOD_W-1:0] p);
        return {{(ACC_W-PERIOD_W){1'b0}}, p};
    endfunction
endpackage

// File: rtl/rtc_adj_ctl.sv
// Temporary period adjustment: a delta applied for a loaded number of cycles.
// A new load always replaces a running adjustment; a count of zero cancels it.
module rtc_adj_ctl
    import rtc_pkg::*;
#(
    parameter int CNT_W = ADJ_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                ld,
    input  logic [CNT_W-1:0]    ld_cnt,
    input  logic [PERIOD_W-1:0] ld_delta,
    output logic                busy,
    output logic [PERIOD_W-1:0] delta_sel
);
    logic [CNT_W-1:0]    cnt_reg;
    logic [PERIOD_W-1:0] delta_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg   <= '0;
            delta_reg <= '0;
        end else begin
            if (ld) begin
                cnt_reg   <= ld_cnt;
                delta_reg <= ld_delta;
            end else if (clr) begin
                cnt_reg <= '0;
            end else if (cnt_reg != '0) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end
        end
    end

    assign busy      = (cnt_reg != '0);
    assign delta_sel = busy ? delta_reg : '0;
endmodule

// File: rtl/rtc_core.sv
// Free-running PTP time-of-day counter (48-bit seconds + 30.8 ns) with 1PPS.
// Time stays frozen after reset until the first period load arrives.
module rtc_core
    import rtc_pkg::*;
#(
    parameter int NS_FRAC_INT = 32,
    parameter int ADJ_CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rtc_rst_in,
    input  logic                 time_ld_in,
    input  logic [NS_W-1:0]      time_reg_ns_in,
    input  logic [SEC_W-1:0]     time_reg_sec_in,
    input  logic                 period_ld_in,
    input  logic [PERIOD_W-1:0]  period_in,
    input  logic [NS_W-1:0]      time_acc_modulo_in,
    input  logic                 adj_ld_in,
    input  logic [ADJ_CNT_W-1:0] adj_ld_data_in,
    input  logic [PERIOD_W-1:0]  period_adj_in,
    output logic [NS_W-1:0]      time_reg_ns_out,
    output logic [SEC_W-1:0]     time_reg_sec_out,
    output logic                 pps_out,
    output logic                 adj_busy_out
);
    localparam int NS_LSB = NS_FRAC_INT - 8;

    logic [PERIOD_W-1:0] period_reg;
    logic [NS_W-1:0]     modulo_reg;
    logic                run_reg;
    logic [ACC_W-1:0]    acc_reg, acc_next;
    logic [SEC_W-1:0]    sec_reg, sec_next;
    logic                pps_reg, pps_next;

    logic [PERIOD_W-1:0] adj_delta;
    logic [PERIOD_W-1:0] inc;
    logic [ACC_W-1:0]    sum;
    logic                roll;

    rtc_adj_ctl #(.CNT_W(ADJ_CNT_W)) u_adj (
        .clk       (clk),
        .rst       (rst),
        .clr       (rtc_rst_in),
        .ld        (adj_ld_in),
        .ld_cnt    (adj_ld_data_in),
        .ld_delta  (period_adj_in),
        .busy      (adj_busy_out),
        .delta_sel (adj_delta)
    );

    // Two's-complement delta wraps within the period width before widening.
    assign inc  = period_reg + adj_delta;
    assign sum  = acc_reg + widen_inc(inc);
    assign roll = (sum[NS_LSB +: NS_W] >= modulo_reg);

    always_comb begin
        acc_next = acc_reg;
        sec_next = sec_reg;
        pps_next = 1'b0;
        if (rtc_rst_in) begin
            acc_next = '0;
            sec_next = '0;
        end else if (time_ld_in) begin
            acc_next = {time_reg_ns_in, {NS_LSB{1'b0}}};
            sec_next = time_reg_sec_in;
        end else if (run_reg) begin
            if (roll) begin
                acc_next = sum - {modulo_reg, {NS_LSB{1'b0}}};
                sec_next = sec_reg + SEC_W'(1);
                pps_next = 1'b1;
            end else begin
                acc_next = sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_reg <= '0;
            modulo_reg <= '0;
            run_reg    <= 1'b0;
            acc_reg    <= '0;
            sec_reg    <= '0;
            pps_reg    <= 1'b0;
        end else begin
            acc_reg <= acc_next;
            sec_reg <= sec_next;
            pps_reg <= pps_next;
            if (period_ld_in) begin
                period_reg <= period_in;
                modulo_reg <= time_acc_modulo_in;
                run_reg    <= 1'b1;
            end
        end
    end

    assign time_reg_ns_out  = acc_reg[NS_LSB +: NS_W];
    assign time_reg_sec_out = sec_reg;
    assign pps_out          = pps_reg;
endmodule

// File: tb/tb_rtc_core.sv
// Directed bench for rtc_core: a time model in 2^-32 ns units checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_rtc_core;
    import rtc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rtc_rst_in = 1'b0;
    logic        time_ld_in = 1'b0;
    logic [37:0] time_reg_ns_in = '0;
    logic [47:0] time_reg_sec_in = '0;
    logic        period_ld_in = 1'b0;
    logic [39:0] period_in = '0;
    logic [37:0] time_acc_modulo_in = '0;
    logic        adj_ld_in = 1'b0;
    logic [31:0] adj_ld_data_in = '0;
    logic [39:0] period_adj_in = '0;
    logic [37:0] time_reg_ns_out;
    logic [47:0] time_reg_sec_out;
    logic        pps_out;
    logic        adj_busy_out;

    int n_vec = 0;
    int n_err = 0;

    rtc_core dut (
        .clk(clk), .rst(rst), .rtc_rst_in(rtc_rst_in), .time_ld_in(time_ld_in),
        .time_reg_ns_in(time_reg_ns_in), .time_reg_sec_in(time_reg_sec_in),
        .period_ld_in(period_ld_in), .period_in(period_in),
        .time_acc_modulo_in(time_acc_modulo_in), .adj_ld_in(adj_ld_in),
        .adj_ld_data_in(adj_ld_data_in), .period_adj_in(period_adj_in),
        .time_reg_ns_out(time_reg_ns_out), .time_reg_sec_out(time_reg_sec_out),
        .pps_out(pps_out), .adj_busy_out(adj_busy_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Time model: the accumulator holds nanoseconds in units of 2^-32 ns.
    localparam logic [63:0] MASK62 = 64'h3FFF_FFFF_FFFF_FFFF;
    logic [63:0] m_acc = '0;
    logic [47:0] m_sec = '0;
    logic [39:0] m_per = '0;
    logic [39:0] m_dlt = '0;
    logic [37:0] m_mod = '0;
    logic [31:0] m_cnt = '0;
    bit          m_run = 1'b0;
    bit          m_pps = 1'b0;

    function automatic logic [64:0] advance(input logic [63:0] acc, input logic [39:0] per,
                                            input logic [39:0] dlt, input logic [37:0] md);
        logic [39:0] step;
        logic [63:0] t;
        logic [63:0] lim;
        step = per + dlt;
        t    = (acc + {24'd0, step}) & MASK62;
        lim  = {26'd0, md} << 24;
        if (t >= lim) return {1'b1, (t - lim) & MASK62};
        return {1'b0, t};
    endfunction

    initial begin
        logic [64:0] r;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_acc = '0; m_sec = '0; m_per = '0; m_dlt = '0;
                m_mod = '0; m_cnt = '0; m_run = 1'b0; m_pps = 1'b0;
            end else begin
                r = advance(m_acc, m_per, (m_cnt != 0) ? m_dlt : 40'd0, m_mod);
                m_pps = 1'b0;
                if (rtc_rst_in) begin
                    m_acc = '0; m_sec = '0;
                end else if (time_ld_in) begin
                    m_acc = {2'b00, time_reg_ns_in, 24'd0};
                    m_sec = time_reg_sec_in;
                end else if (m_run) begin
                    m_acc = r[63:0];
                    if (r[64]) begin
                        m_sec = m_sec + 48'd1;
                        m_pps = 1'b1;
                    end
                end
                if (adj_ld_in) begin
                    m_cnt = adj_ld_data_in; m_dlt = period_adj_in;
                end else if (rtc_rst_in) m_cnt = '0;
                else if (m_cnt != 0) m_cnt = m_cnt - 32'd1;
                if (period_ld_in) begin
                    m_per = period_in; m_mod = time_acc_modulo_in; m_run = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                check("model_ns",   64'(time_reg_ns_out),  64'(m_acc[61:24]));
                check("model_sec",  64'(time_reg_sec_out), 64'(m_sec));
                check("model_pps",  64'(pps_out),          64'(m_pps));
                check("model_busy", 64'(adj_busy_out),     64'(m_cnt != 0));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        rtc_rst_in = 0; time_ld_in = 0; period_ld_in = 0; adj_ld_in = 0;
    endtask

    task automatic show(input string step);
        $display("%s: ns=%0h sec=%0h pps=%0b busy=%0b", step, time_reg_ns_out,
                 time_reg_sec_out, pps_out, adj_busy_out);
    endtask

    logic [37:0] up_ns [5]   = '{38'h900, 38'h1200, 38'h1B00, 38'h2300, 38'h2B00};
    logic [37:0] dn_ns [5]   = '{38'h700, 38'hE00, 38'h1500, 38'h1D00, 38'h2500};
    logic        adj_bsy [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        repeat (3) tick();
        rst = 1;
        repeat (4) tick();
        check("frozen_ns", 64'(time_reg_ns_out), 64'd0);
        check("frozen_sec", 64'(time_reg_sec_out), 64'd0);
        show("frozen");

        // Rollover from just below one second
        period_ld_in = 1; period_in = 40'h08_0000_0000; time_acc_modulo_in = NS_1E9;
        time_ld_in = 1; time_reg_ns_in = 38'h3B9AC9F800; time_reg_sec_in = 48'd5;
        tick(); clear_pulses();
        check("roll_load_ns", 64'(time_reg_ns_out), 64'h3B9AC9F800);
        check("roll_load_sec", 64'(time_reg_sec_out), 64'd5);
        show("roll_load");
        tick();
        check("roll_ns", 64'(time_reg_ns_out), 64'd0);
        check("roll_sec", 64'(time_reg_sec_out), 64'd6);
        check("roll_pps", 64'(pps_out), 64'd1);
        show("roll");
        tick();
        check("roll_after_ns", 64'(time_reg_ns_out), 64'h800);
        check("roll_after_pps", 64'(pps_out), 64'd0);
        show("roll_after");

        // Reset mid-run with an adjustment active
        adj_ld_in = 1; adj_ld_data_in = 32'd100; period_adj_in = 40'h01_0000_0000;
        tick(); clear_pulses();
        repeat (3) tick();
        #2 rst = 0;
        #1;
        check("rst_ns", 64'(time_reg_ns_out), 64'd0);
        check("rst_sec", 64'(time_reg_sec_out), 64'd0);
        check("rst_pps", 64'(pps_out), 64'd0);
        check("rst_busy", 64'(adj_busy_out), 64'd0);
        show("reset");
        repeat (2) tick();
        rst = 1;
        repeat (3) tick();
        check("post_rst_ns", 64'(time_reg_ns_out), 64'd0);
        check("post_rst_sec", 64'(time_reg_sec_out), 64'd0);
        show("post_reset");

        // Fractional period 8.5 ns
        period_ld_in = 1; period_in = 40'h08_8000_0000; time_acc_modulo_in = NS_1E9;
        time_ld_in = 1; time_reg_ns_in = '0; time_reg_sec_in = '0;
        tick(); clear_pulses();
        check("frac_load_ns", 64'(time_reg_ns_out), 64'd0);
        repeat (2) tick();
        check("frac_ns", 64'(time_reg_ns_out), 64'h1100);
        show("fraction");

        // Positive then negative adjustment
        for (int pass = 0; pass < 2; pass++) begin
            period_ld_in = 1; period_in = 40'h08_0000_0000;
            time_ld_in = 1; time_reg_ns_in = '0; time_reg_sec_in = '0;
            adj_ld_in = 1; adj_ld_data_in = 32'd3;
            period_adj_in = (pass == 0) ? 40'h01_0000_0000 : 40'hFF_0000_0000;
            tick(); clear_pulses();
            check("adj_load_ns", 64'(time_reg_ns_out), 64'd0);
            check("adj_load_busy", 64'(adj_busy_out), 64'd1);
            for (int i = 0; i < 5; i++) begin
                tick();
                check("adj_ns", 64'(time_reg_ns_out), 64'((pass == 0) ? up_ns[i] : dn_ns[i]));
                check("adj_busy", 64'(adj_busy_out), 64'(adj_bsy[i]));
                show((pass == 0) ? "adj_up" : "adj_down");
            end
        end

        // Adjustment cancelled by a zero-length load
        adj_ld_in = 1; adj_ld_data_in = 32'd5; period_adj_in = 40'h01_0000_0000;
        tick();
        adj_ld_data_in = 32'd0;
        tick(); clear_pulses();
        check("cancel_busy", 64'(adj_busy_out), 64'd0);
        show("cancel");

        // rtc_rst and time_ld together during an adjustment
        adj_ld_in = 1; adj_ld_data_in = 32'd3; period_adj_in = 40'h01_0000_0000;
        time_ld_in = 1; time_reg_ns_in = 38'h100; time_reg_sec_in = 48'd7;
        tick(); clear_pulses();
        rtc_rst_in = 1; time_ld_in = 1; time_reg_ns_in = 38'h3B9AC9F800; time_reg_sec_in = 48'd9;
        tick(); clear_pulses();
        check("prio_ns", 64'(time_reg_ns_out), 64'd0);
        check("prio_sec", 64'(time_reg_sec_out), 64'd0);
        check("prio_busy", 64'(adj_busy_out), 64'd0);
        show("priority");
        tick();
        check("prio_period_ns", 64'(time_reg_ns_out), 64'h800);
        show("priority_after");

        // Seconds wrap at the top of the 48-bit range
        time_ld_in = 1; time_reg_ns_in = 38'h3B9AC9F800; time_reg_sec_in = 48'hFFFF_FFFF_FFFF;
        tick(); clear_pulses();
        check("wrap_load_sec", 64'(time_reg_sec_out), 64'hFFFF_FFFF_FFFF);
        tick();
        check("wrap_sec", 64'(time_reg_sec_out), 64'd0);
        check("wrap_ns", 64'(time_reg_ns_out), 64'd0);
        check("wrap_pps", 64'(pps_out), 64'd1);
        show("sec_wrap");
        tick();
        check("wrap_after_pps", 64'(pps_out), 64'd0);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
